alpu_iqueue: RTL and testbench

//  Per-exec-unit in-order instruction queue sitting directly upstream of alpu_cache.
//  - Buffers decoded type_iqueue_entry words from dispatch.
//  - Presents the head entry to alpu_cache as ireq_curr_instr and retires it when the ALPU acks issue.
//  - Provides occupancy and a head-of-line stall watchdog for debug/perf.

---
 rtl/exec_unit_dtypes.sv | 18 +
 rtl/alpu_iqueue.sv | 82 ++++++++
 tb/tb_alpu_iqueue.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/exec_unit_dtypes.sv
// Shared exec-unit datatypes: the decoded instruction-queue entry and the
// default queue sizing used when the exec unit top instantiates alpu_iqueue.
package exec_unit_dtypes;

  localparam int IQUEUE_DEPTH       = 4;
  localparam int IQUEUE_STALL_LIMIT = 255;

  // op0m/op1m request operand reads from alpu_cache; all-zero means no reads.
  typedef struct packed {
    logic [3:0] opcode;
    logic       op0m;
    logic       op1m;
    logic [7:0] op0;
    logic [7:0] op1;
    logic [4:0] dst;
  } type_iqueue_entry;

endpackage

// File: rtl/alpu_iqueue.sv
// In-order instruction queue feeding alpu_cache: buffers dispatch entries,
// presents the head until the ALPU acks issue, and watches for head-of-line stalls.
module alpu_iqueue
  import exec_unit_dtypes::*;
#(
  parameter int DEPTH       = IQUEUE_DEPTH,
  parameter int STALL_LIMIT = IQUEUE_STALL_LIMIT
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush_i,
  input  type_iqueue_entry             dec_instr_i,
  input  logic                         dec_valid_i,
  output logic                         dec_ready_o,
  output type_iqueue_entry             ireq_curr_instr,
  output logic                         ireq_valid_o,
  input  logic                         issue_ack_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         stall_timeout_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STALL_LIMIT);

  type_iqueue_entry mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;
  logic          push, pop;

  // Ready depends only on registered occupancy, so an ack cannot free a slot in the same cycle.
  assign dec_ready_o     = reset_n & (count_q < CW'(DEPTH)) & ~flush_i;
  assign ireq_valid_o    = (count_q != '0);
  assign ireq_curr_instr = ireq_valid_o ? mem_q[rd_ptr_q] : '0;
  assign push            = dec_valid_i & dec_ready_o;
  assign pop             = issue_ack_i & ireq_valid_o & ~flush_i;
  assign count_o         = count_q;
  assign stall_timeout_o = (stall_cnt_q == LIMIT);

  always_comb begin
    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    count_d     = count_q + CW'(push) - CW'(pop);
    stall_cnt_d = stall_cnt_q;
    if (pop || !ireq_valid_o) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q != LIMIT) begin
      stall_cnt_d = stall_cnt_q + SW'(1);
    end
    if (flush_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      stall_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Storage is deliberately unreset; validity comes from count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= dec_instr_i;
    end
  end

endmodule

// File: tb/tb_alpu_iqueue.sv
// Directed self-checking bench for alpu_iqueue (DEPTH=4, STALL_LIMIT=8).
module tb_alpu_iqueue;
  import exec_unit_dtypes::*;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             flush_i;
  type_iqueue_entry dec_instr_i;
  logic             dec_valid_i;
  logic             dec_ready_o;
  type_iqueue_entry ireq_curr_instr;
  logic             ireq_valid_o;
  logic             issue_ack_i;
  logic [2:0]       count_o;
  logic             stall_timeout_o;

  int errors = 0;
  int checks = 0;

  alpu_iqueue #(.DEPTH(4), .STALL_LIMIT(8)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .flush_i         (flush_i),
    .dec_instr_i     (dec_instr_i),
    .dec_valid_i     (dec_valid_i),
    .dec_ready_o     (dec_ready_o),
    .ireq_curr_instr (ireq_curr_instr),
    .ireq_valid_o    (ireq_valid_o),
    .issue_ack_i     (issue_ack_i),
    .count_o         (count_o),
    .stall_timeout_o (stall_timeout_o)
  );

  always #5 clk = ~clk;

  function automatic type_iqueue_entry mk(input logic [7:0] v);
    type_iqueue_entry e;
    e.opcode = v[3:0];
    e.op0m   = 1'b1;
    e.op1m   = 1'b1;
    e.op0    = v;
    e.op1    = ~v;
    e.dst    = v[4:0];
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ack is never legal against an empty queue; verify before every edge.
  task automatic tick();
    check("ack_while_empty", 64'(issue_ack_i & ~ireq_valid_o), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n     = 1'b0;
    flush_i     = 1'b0;
    dec_instr_i = '0;
    dec_valid_i = 1'b0;
    issue_ack_i = 1'b0;
    #3;
    check("rst_ready", 64'(dec_ready_o), 64'd0);
    check("rst_valid", 64'(ireq_valid_o), 64'd0);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_head", 64'(ireq_curr_instr), 64'd0);
    check("rst_timeout", 64'(stall_timeout_o), 64'd0);
    #9 reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", 64'(dec_ready_o), 64'd1);

    // Test 1: push A,B,C back-to-back with no ack; no same-cycle bypass.
    dec_valid_i = 1'b1;
    dec_instr_i = mk(8'h01);
    #1;
    check("t1_no_bypass_valid", 64'(ireq_valid_o), 64'd0);
    check("t1_no_bypass_head", 64'(ireq_curr_instr), 64'd0);
    tick();
    check("t1_headA", 64'(ireq_curr_instr), 64'(mk(8'h01)));
    check("t1_count1", 64'(count_o), 64'd1);
    check("t1_ready1", 64'(dec_ready_o), 64'd1);
    dec_instr_i = mk(8'h02);
    tick();
    check("t1_count2", 64'(count_o), 64'd2);
    check("t1_headA2", 64'(ireq_curr_instr), 64'(mk(8'h01)));
    dec_instr_i = mk(8'h03);
    tick();
    check("t1_count3", 64'(count_o), 64'd3);
    check("t1_ready3", 64'(dec_ready_o), 64'd1);

    // Test 2: fill to 4, hold valid with E; ack on full does not admit E that cycle.
    dec_instr_i = mk(8'h04);
    tick();
    check("t2_count4", 64'(count_o), 64'd4);
    check("t2_full_ready", 64'(dec_ready_o), 64'd0);
    dec_instr_i = mk(8'h05);
    issue_ack_i = 1'b1;
    #1;
    check("t2_ack_ready", 64'(dec_ready_o), 64'd0);
    tick();
    check("t2_count3", 64'(count_o), 64'd3);
    check("t2_headB", 64'(ireq_curr_instr), 64'(mk(8'h02)));
    check("t2_ready_after_pop", 64'(dec_ready_o), 64'd1);
    issue_ack_i = 1'b0;
    tick();
    check("t2_count4b", 64'(count_o), 64'd4);
    check("t2_headB2", 64'(ireq_curr_instr), 64'(mk(8'h02)));
    dec_valid_i = 1'b0;

    // Test 3: drain to 2 (D,E), then push+ack for 10 cycles; pointers wrap.
    issue_ack_i = 1'b1;
    tick();
    check("t3_headC", 64'(ireq_curr_instr), 64'(mk(8'h03)));
    tick();
    check("t3_count2", 64'(count_o), 64'd2);
    check("t3_headD", 64'(ireq_curr_instr), 64'(mk(8'h04)));
    dec_valid_i = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      dec_instr_i = mk(8'(i + 5));
      tick();
      check($sformatf("t3_count_%0d", i), 64'(count_o), 64'd2);
      check($sformatf("t3_head_%0d", i), 64'(ireq_curr_instr),
            64'(mk((i == 1) ? 8'h05 : 8'(i + 4))));
    end
    dec_valid_i = 1'b0;
    issue_ack_i = 1'b0;

    // Test 4: flush, push two, then flush together with push and ack.
    flush_i = 1'b1;
    tick();
    check("t4_flush0_count", 64'(count_o), 64'd0);
    flush_i     = 1'b0;
    dec_valid_i = 1'b1;
    dec_instr_i = mk(8'h20);
    tick();
    dec_instr_i = mk(8'h21);
    tick();
    check("t4_count2", 64'(count_o), 64'd2);
    check("t4_head20", 64'(ireq_curr_instr), 64'(mk(8'h20)));
    dec_instr_i = mk(8'h22);
    issue_ack_i = 1'b1;
    flush_i     = 1'b1;
    #1;
    check("t4_flush_ready", 64'(dec_ready_o), 64'd0);
    tick();
    check("t4_count0", 64'(count_o), 64'd0);
    check("t4_valid0", 64'(ireq_valid_o), 64'd0);
    check("t4_head0", 64'(ireq_curr_instr), 64'd0);
    issue_ack_i = 1'b0;
    flush_i     = 1'b0;
    dec_valid_i = 1'b0;
    tick();
    check("t4_push_absent", 64'(count_o), 64'd0);

    // Test 5: one stalled entry; timeout after 8 stalled cycles, saturates, clears on pop.
    dec_valid_i = 1'b1;
    dec_instr_i = mk(8'h30);
    tick();
    dec_valid_i = 1'b0;
    check("t5_count1", 64'(count_o), 64'd1);
    for (int i = 0; i < 7; i++) tick();
    check("t5_timeout_7", 64'(stall_timeout_o), 64'd0);
    tick();
    check("t5_timeout_8", 64'(stall_timeout_o), 64'd1);
    tick();
    tick();
    tick();
    check("t5_timeout_held", 64'(stall_timeout_o), 64'd1);
    issue_ack_i = 1'b1;
    tick();
    issue_ack_i = 1'b0;
    check("t5_timeout_clear", 64'(stall_timeout_o), 64'd0);
    check("t5_count0", 64'(count_o), 64'd0);

    // Test 6: async reset mid-cycle with 3 entries, then push D after release.
    dec_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dec_instr_i = mk(8'(8'h40 + i));
      tick();
    end
    dec_valid_i = 1'b0;
    check("t6_count3", 64'(count_o), 64'd3);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_count", 64'(count_o), 64'd0);
    check("t6_rst_valid", 64'(ireq_valid_o), 64'd0);
    check("t6_rst_head", 64'(ireq_curr_instr), 64'd0);
    check("t6_rst_ready", 64'(dec_ready_o), 64'd0);
    #1 reset_n = 1'b1;
    tick();
    check("t6_ready", 64'(dec_ready_o), 64'd1);
    check("t6_count_post", 64'(count_o), 64'd0);
    dec_valid_i = 1'b1;
    dec_instr_i = mk(8'h44);
    tick();
    dec_valid_i = 1'b0;
    check("t6_headD", 64'(ireq_curr_instr), 64'(mk(8'h44)));
    check("t6_count1", 64'(count_o), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
